// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between two masters.
// Option: define MEM_ARB_FIXED_PRIO_EN for strict port-0 priority.
module mem_arbiter #(
    parameter int WIDTH = 8,
    parameter int LENGTH = 256,
    localparam int ADDR_WIDTH = $clog2(LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] a0,
    input  logic [WIDTH-1:0]      wd0,
    output logic                  ack0,
    output logic [WIDTH-1:0]      rd0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] a1,
    input  logic [WIDTH-1:0]      wd1,
    output logic                  ack1,
    output logic [WIDTH-1:0]      rd1,
    output logic [1:0]            gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0]      mem_wd,
    input  logic [WIDTH-1:0]      mem_rd
);

    logic             r_ack0;
    logic             r_ack1;
    logic             r_last_gnt;
    logic [WIDTH-1:0] r_rd0;
    logic [WIDTH-1:0] r_rd1;

    logic w_elig0;
    logic w_elig1;
    logic w_pick0;
    logic w_pick1;
    logic w_gnt0;
    logic w_gnt1;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // last_gnt is tracked but plays no part in the decision here
    logic w_unused_last;
    assign w_unused_last = r_last_gnt;
`endif

    // Eligibility and arbitration; a port in its ack cycle sits out
    always_comb begin
        w_elig0 = req0 & ~r_ack0;
        w_elig1 = req1 & ~r_ack1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        w_pick0 = w_elig0;
        w_pick1 = w_elig1 & ~w_elig0;
`else
        w_pick0 = w_elig0 & (~w_elig1 | r_last_gnt);
        w_pick1 = w_elig1 & (~w_elig0 | ~r_last_gnt);
`endif
        // No grant while in reset, so release never commits a write
        w_gnt0 = w_pick0 & rst_n;
        w_gnt1 = w_pick1 & rst_n;
    end

    // Steer the winning port onto the memory pins; idle shows port 0
    always_comb begin
        mem_a  = a0;
        mem_wd = wd0;
        mem_we = we0 & w_gnt0;
        if (w_gnt1) begin
            mem_a  = a1;
            mem_wd = wd1;
            mem_we = we1;
        end
    end

    // Ack pulse and read-data capture for the granted port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_rd0  <= '0;
            r_rd1  <= '0;
        end else begin
            r_ack0 <= w_gnt0;
            r_ack1 <= w_gnt1;
            if (w_gnt0) begin
                r_rd0 <= mem_rd;
            end
            if (w_gnt1) begin
                r_rd1 <= mem_rd;
            end
        end
    end

    // Remember the last winner; reset favours port 0 on the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
        end else if (w_gnt0 | w_gnt1) begin
            r_last_gnt <= w_gnt1;
        end
    end

    assign gnt  = {w_gnt1, w_gnt0};
    assign ack0 = r_ack0;
    assign ack1 = r_ack1;
    assign rd0  = r_rd0;
    assign rd1  = r_rd1;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter that shares one single-port `memory` instance (combinational read, synchronous write) between two masters, e.g. instruction fetch (port 0) and data/load-store (port 1).
- Grants at most one access per cycle.
- Drives the memory's we/a/wd pins.
- Returns registered read data and a one-cycle ack to the winning port.
- Sits between the core's bus masters and the `memory` block.

Parameters:
WIDTH, 8, data word width; must match the attached memory's WIDTH
LENGTH, 256, memory depth in words; must match the attached memory's LENGTH
ADDR_WIDTH, $clog2(LENGTH), localparam, address width

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  port 0 access request; hold with we0/a0/wd0 stable until ack0
we0  in  1  port 0 write (1) / read (0)
a0  in  ADDR_WIDTH  port 0 address
wd0  in  WIDTH  port 0 write data
ack0  out  1  port 0 access complete (registered)
rd0  out  WIDTH  port 0 read data, valid while ack0=1 (registered)
req1, we1, a1, wd1, ack1, rd1: same as port 0, for port 1
gnt  out  2  one-hot combinational grant for the current cycle; 00 = idle
mem_we  out  1  to memory we
mem_a  out  ADDR_WIDTH  to memory a
mem_wd  out  WIDTH  to memory wd
mem_rd  in  WIDTH  from memory rd

Behaviour:
- Reset values, asynchronous on rst_n=0:
  - ack0=ack1=0, rd0=rd1=0.
  - last_gnt register=1, so port 0 wins the first tie.
  - While rst_n=0, gnt=00 and mem_we=0 regardless of requests. This guarantees no write commits on the edge at which reset is released.
- Eligibility: port i is eligible in cycle N iff req_i=1 and ack_i=0 in cycle N.
  - A port is therefore never re-granted in the cycle its ack is shown; the requester uses that cycle to drop req or present the next request.
- Arbitration is combinational in cycle N:
  - Only one port eligible: that port is granted.
  - Both eligible: round-robin; the port not equal to last_gnt is granted.
  - None eligible: gnt=00, mem_we=0, mem_a=a0, mem_wd=wd0 (don't-care, held deterministic).
- Memory drive: mem_a=a_g, mem_wd=wd_g, mem_we=we_g & grant-valid, where g is the granted port.
- Write: commits at the rising edge ending cycle N.
- Read: mem_rd is sampled at that same edge into rd_g.
- At the edge ending N:
  - ack_g<=1, last_gnt<=g.
  - Non-granted port: ack<=0, rd holds its previous value.
  - On a granted write, rd_g is loaded with mem_rd, i.e. the old contents; benches must not rely on it.
- Latency: request seen in cycle N and granted → ack in N+1. Under contention, the loser is granted in N+1 and acked in N+2.
- Throughput:
  - Max one access per 2 cycles per port.
  - Both ports continuously requesting → grants alternate 0,1,0,1 and the memory is busy every cycle.
- ack is a single-cycle pulse unless the port is re-granted in the immediately following cycle. This cannot happen, because of the eligibility rule, so ack never stays high for 2 consecutive cycles.
- Reset mid-operation: a pending grant is discarded, acks clear, and the requester must re-issue after reset.
- Addresses are used as-is; no range check (ADDR_WIDTH covers LENGTH when LENGTH is a power of 2).

Optional Feature:
MEM_ARB_FIXED_PRIO_EN
- Defined: strict priority, port 0 always wins when both are eligible; last_gnt is still updated but not used for decisions. Port 1 is only granted when port 0 is not eligible, e.g. in port 0's ack cycle, so port 1 still progresses at least every other cycle.
- Undefined: round-robin as above.

Test Plan:
- Reset: hold rst_n=0 with req0=1, we0=1, a0=5, wd0=8'hAA → gnt=00, mem_we=0. After release, a read of addr 5 does not return 8'hAA unless it was written after reset.
- Single port write/read: port 0 writes 8'h3C to addr 10 (ack0 high exactly 1 cycle after request), then reads addr 10 → ack0 in the next cycle with rd0=8'h3C; ack1 stays 0 throughout.
- Contention, round-robin: from reset both ports request simultaneously and keep requesting (port 0 reads addr 1 holding 8'h11, port 1 reads addr 2 holding 8'h22) → gnt sequence 01,10,01,10; rd0=8'h11 on each ack0, rd1=8'h22 on each ack1.
- Write/read race: port 1 writes 8'h77 to addr 20 while port 0 reads addr 20 in the same cycle, port 1 winning by last_gnt=0 → the port 0 read is served the next cycle and returns 8'h77.
- Reset mid-operation: assert rst_n=0 in the grant cycle of a port 1 write of 8'hFF to addr 30 (addr 30 previously 8'h00) → ack1=0 immediately; after reset, reading addr 30 returns 8'h00.
- With MEM_ARB_FIXED_PRIO_EN: both ports continuously requesting → gnt=01,10,01,10 (port 1 only in port 0's ack cycle); with port 0's req removed, port 1 is granted every other cycle.
